// File: rtl/resistor_capacitor_high_pass_filter.sv
// Multi-channel first-order RC high-pass filter (DC blocker).
// Each channel keeps a low-pass state lp and outputs in - lp. A single signed
// multiplier is shared across channels by a two-state sequencer that is kicked
// off by the audio_clk_en sample strobe. A strobe that arrives while the
// sequencer is busy is held in a one-deep pending slot; any further strobe
// before that slot is consumed sets the sticky overrun flag.
//
// Optional build macro HPF_SATURATE_EN:
//   defined   - the high-pass output clamps to the signed 16-bit range
//   undefined - the high-pass output wraps to its low 16 bits
module resistor_capacitor_high_pass_filter #(
  parameter int  NUM_CHANNELS = 2,
  parameter int  SAMPLE_RATE  = 48000,
  parameter real R            = 47000.0,
  parameter real C            = 47e-9
) (
  input  logic                      clk,
  input  logic                      I_RSTn,
  input  logic                      audio_clk_en,
  input  logic [16*NUM_CHANNELS-1:0] in,
  output logic [16*NUM_CHANNELS-1:0] out,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun
);

  // Filter coefficient: fraction of the error the low-pass state moves by
  // per sample, in Q16. The real-to-int conversion truncates.
  localparam real RCN = R * C * (SAMPLE_RATE * 1.0);
  localparam int  M   = $rtoi(65536.0 / (1.0 + RCN));
  localparam logic signed [17:0] M_S = 18'(M);

  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [16*NUM_CHANNELS-1:0] inReg_q;
  logic [16*NUM_CHANNELS-1:0] out_q;
  logic signed [15:0]         lp_q [NUM_CHANNELS];
  logic [CW-1:0]              chIdx_q;
  logic                       pending_q;
  logic                       overrun_q;
  logic                       outValid_q;

  logic                       startRun;
  logic                       lastCh;
  logic [CW+3:0]              chBase;
  logic signed [15:0]         curIn;
  logic signed [15:0]         curLp;
  logic signed [16:0]         diff;
  logic signed [34:0]         prod;
  logic signed [34:0]         prodSh;
  logic signed [16:0]         delta;
  logic signed [15:0]         lpNext;
  logic signed [17:0]         outWide;
  logic signed [15:0]         outSat;
  logic                       unusedBits;

  assign startRun = audio_clk_en || pending_q;
  assign lastCh   = (chIdx_q == LAST_CH);
  assign chBase   = {chIdx_q, 4'b0000};

  // Shared datapath for the channel currently selected by the sequencer.
  always_comb begin
    curIn   = inReg_q[chBase +: 16];
    curLp   = lp_q[chIdx_q];
    diff    = {curIn[15], curIn} - {curLp[15], curLp};
    prod    = diff * M_S;
    prodSh  = prod >>> 16;
    delta   = prodSh[16:0];
    lpNext  = curLp + delta[15:0];
    outWide = {diff[16], diff} - {delta[16], delta};
  end

  // Map the 18-bit high-pass result onto the 16-bit output.
`ifdef HPF_SATURATE_EN
  always_comb begin
    if (outWide > 18'sd32767) begin
      outSat = 16'sh7FFF;
    end else if (outWide < -18'sd32768) begin
      outSat = 16'sh8000;
    end else begin
      outSat = outWide[15:0];
    end
  end
  assign unusedBits = ^{prodSh[34:17], delta[16]};
`else
  always_comb begin
    outSat = outWide[15:0];
  end
  assign unusedBits = ^{prodSh[34:17], delta[16], outWide[17:16]};
`endif

  // Sequencer state register.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: leave IDLE on a strobe or pending request, return after the last channel.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (startRun) state_d = RUN;
      RUN:     if (lastCh)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer outputs.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Sample capture, per-channel filter update, pending/overrun bookkeeping.
  always_ff @(posedge clk or negedge I_RSTn) begin
    if (!I_RSTn) begin
      out_q      <= '0;
      inReg_q    <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      outValid_q <= 1'b0;
      chIdx_q    <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        lp_q[k] <= '0;
      end
    end else begin
      outValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startRun) begin
            inReg_q   <= in;
            pending_q <= 1'b0;
            chIdx_q   <= '0;
            if (audio_clk_en && pending_q) begin
              overrun_q <= 1'b1;
            end
          end
        end
        RUN: begin
          lp_q[chIdx_q]      <= lpNext;
          out_q[chBase +: 16] <= outSat;
          if (audio_clk_en) begin
            if (pending_q) begin
              overrun_q <= 1'b1;
            end else begin
              pending_q <= 1'b1;
            end
          end
          if (lastCh) begin
            outValid_q <= 1'b1;
            chIdx_q    <= '0;
          end else begin
            chIdx_q <= chIdx_q + 1'b1;
          end
        end
        default: begin
          chIdx_q <= '0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = outValid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_resistor_capacitor_high_pass_filter.sv
// Self-checking bench for resistor_capacitor_high_pass_filter.
// Two instances: the default coefficient and a fast (R=10k, C=10n) one used
// to drive the output into its 16-bit limits.
module tb_resistor_capacitor_high_pass_filter;

  logic        clk;
  logic        rstN;
  logic        stb1, stb2;
  logic [31:0] in1, in2;
  logic [31:0] out1, out2;
  logic        v1, v2, b1, b2, o1, o2;

  int checks;
  int failures;
  int vcount1;
  int mCoef [2];
  int lpM [2][2];
  int expOut [2][2];

  resistor_capacitor_high_pass_filter #(.NUM_CHANNELS(2)) dut (
    .clk(clk), .I_RSTn(rstN), .audio_clk_en(stb1), .in(in1),
    .out(out1), .out_valid(v1), .busy(b1), .overrun(o1)
  );

  resistor_capacitor_high_pass_filter #(
    .NUM_CHANNELS(2), .SAMPLE_RATE(48000), .R(10000.0), .C(1e-8)
  ) dutSat (
    .clk(clk), .I_RSTn(rstN), .audio_clk_en(stb2), .in(in2),
    .out(out2), .out_valid(v2), .busy(b2), .overrun(o2)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count out_valid pulses of the default instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (v1 === 1'b1) vcount1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int getOut(input int d, input int ch);
    logic [31:0]        v;
    logic signed [15:0] s;
    v = (d == 0) ? out1 : out2;
    s = v[16*ch +: 16];
    return int'(s);
  endfunction

  function automatic logic getValid(input int d);
    return (d == 0) ? v1 : v2;
  endfunction

  function automatic logic getBusy(input int d);
    return (d == 0) ? b1 : b2;
  endfunction

  task automatic setIn(input int d, input int a, input int b);
    logic [15:0] ua, ub;
    ua = 16'(a);
    ub = 16'(b);
    if (d == 0) in1 = {ub, ua};
    else        in2 = {ub, ua};
  endtask

  task automatic setStb(input int d, input logic val);
    if (d == 0) stb1 = val;
    else        stb2 = val;
  endtask

  function automatic void modelReset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 2; c++) begin
        lpM[d][c]    = 0;
        expOut[d][c] = 0;
      end
    end
  endfunction

  // Reference: lp moves by floor(M*(in-lp)/65536); output is the residual.
  function automatic int modelProcess(input int d, input int ch, input int x);
    int     diff, delta, y;
    longint p;
    diff = x - lpM[d][ch];
    p = longint'(mCoef[d]) * longint'(diff);
    if (p >= 0) delta = int'(p / 65536);
    else        delta = -int'((-p + 65535) / 65536);
    lpM[d][ch] = lpM[d][ch] + delta;
    y = diff - delta;
`ifdef HPF_SATURATE_EN
    if (y > 32767)       y = 32767;
    else if (y < -32768) y = -32768;
`else
    y = y & 32'h0000FFFF;
    if (y >= 32768) y = y - 65536;
`endif
    return y;
  endfunction

  task automatic applyReset();
    rstN = 1'b0;
    stb1 = 1'b0; stb2 = 1'b0;
    in1 = '0; in2 = '0;
    tick();
    tick();
    rstN = 1'b1;
    tick();
    modelReset();
  endtask

  // One strobe, then check per-channel update timing and the out_valid pulse.
  task automatic doSample(input int d, input int a, input int b, input string tag);
    int newExp [2];
    int got, want;
    newExp[0] = modelProcess(d, 0, a);
    newExp[1] = modelProcess(d, 1, b);
    setIn(d, a, b);
    setStb(d, 1'b1);
    tick();
    setStb(d, 1'b0);
    checks++;
    if (getBusy(d) !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s busy_after_strobe: got=%b expected=1", tag, getBusy(d));
    end
    for (int ch = 0; ch < 2; ch++) begin
      tick();
      expOut[d][ch] = newExp[ch];
      for (int c = 0; c < 2; c++) begin
        got  = getOut(d, c);
        want = expOut[d][c];
        checks++;
        if (got !== want) begin
          failures++;
          $display("[TB] FAIL %s out_ch%0d_step%0d: got=%0d expected=%0d", tag, c, ch, got, want);
        end
      end
      checks++;
      if (getValid(d) !== (ch == 1)) begin
        failures++;
        $display("[TB] FAIL %s out_valid_step%0d: got=%b expected=%b", tag, ch, getValid(d), (ch == 1));
      end
    end
    tick();
    checks++;
    if (getValid(d) !== 1'b0 || getBusy(d) !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s idle_after_run: valid=%b busy=%b expected 0 0", tag, getValid(d), getBusy(d));
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    stb1 = 1'b0; stb2 = 1'b0;
    in1 = 32'h1234_5678; in2 = 32'h8765_4321;
    #3;
    checks++;
    if (out1 !== 32'd0 || v1 !== 1'b0 || b1 !== 1'b0 || o1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state: out=%h valid=%b busy=%b overrun=%b expected all 0", out1, v1, b1, o1);
    end
    tick();
    rstN = 1'b1;
    tick();
    checks++;
    if (out1 !== 32'd0 || b1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_hold: out=%h busy=%b expected 0 0", out1, b1);
    end
    modelReset();
  endtask

  task automatic test_basic();
    applyReset();
    doSample(0, 10000, -10000, "basic");
    checks++;
    if (getOut(0, 0) !== 9907 || getOut(0, 1) !== -9906) begin
      failures++;
      $display("[TB] FAIL basic_literal: got=%0d,%0d expected=9907,-9906", getOut(0, 0), getOut(0, 1));
    end
    doSample(0, 10000, -10000, "basic_second");
  endtask

  task automatic test_zero();
    int startCount;
    applyReset();
    startCount = vcount1;
    for (int i = 0; i < 10; i++) doSample(0, 0, 0, "zero");
    checks++;
    if (vcount1 - startCount !== 10 || o1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_pulses: pulses=%0d overrun=%b expected 10 0", vcount1 - startCount, o1);
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int i = 0; i < 24; i++) begin
      doSample(0, int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768, "random");
    end
    checks++;
    if (o1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL random_overrun: got=%b expected=0", o1);
    end
  endtask

  task automatic test_saturation();
    int want;
    applyReset();
    for (int i = 0; i < 64; i++) doSample(1, -32768, 0, "sat_settle");
    doSample(1, 32767, 0, "sat_step");
`ifdef HPF_SATURATE_EN
    want = 32767;
`else
    want = -11299;
`endif
    checks++;
    if (getOut(1, 0) !== want) begin
      failures++;
      $display("[TB] FAIL sat_literal: got=%0d expected=%0d", getOut(1, 0), want);
    end
  endtask

  task automatic test_back_to_back();
    int startCount;
    int eA [2], eB [2], eC [2];
    int a0, a1, bb0, bb1, c0, c1;
    applyReset();
    a0 = -12000; a1 = 7000; bb0 = 20000; bb1 = -3000;
    eA[0] = modelProcess(0, 0, a0);  eA[1] = modelProcess(0, 1, a1);
    eB[0] = modelProcess(0, 0, bb0); eB[1] = modelProcess(0, 1, bb1);
    startCount = vcount1;
    setIn(0, a0, a1);
    stb1 = 1'b1;
    tick();
    stb1 = 1'b0;
    tick();
    stb1 = 1'b1;
    tick();
    stb1 = 1'b0;
    setIn(0, bb0, bb1);
    checks++;
    if (b1 !== 1'b0 || getOut(0, 0) !== eA[0] || getOut(0, 1) !== eA[1]) begin
      failures++;
      $display("[TB] FAIL pend_first_run: busy=%b out=%0d,%0d expected 0 %0d,%0d",
               b1, getOut(0, 0), getOut(0, 1), eA[0], eA[1]);
    end
    tick();
    tick();
    checks++;
    if (getOut(0, 0) !== eB[0] || getOut(0, 1) !== eA[1]) begin
      failures++;
      $display("[TB] FAIL pend_ch0: out=%0d,%0d expected=%0d,%0d", getOut(0, 0), getOut(0, 1), eB[0], eA[1]);
    end
    tick();
    tick();
    checks++;
    if (getOut(0, 1) !== eB[1] || vcount1 - startCount !== 2 || o1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL pend_done: ch1=%0d pulses=%0d overrun=%b expected %0d 2 0",
               getOut(0, 1), vcount1 - startCount, o1, eB[1]);
    end
    expOut[0][0] = eB[0]; expOut[0][1] = eB[1];

    c0 = 5000; c1 = -25000;
    eC[0] = modelProcess(0, 0, c0); eC[1] = modelProcess(0, 1, c1);
    eC[0] = modelProcess(0, 0, c0); eC[1] = modelProcess(0, 1, c1);
    startCount = vcount1;
    setIn(0, c0, c1);
    stb1 = 1'b1;
    tick();
    tick();
    tick();
    stb1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (o1 !== 1'b1 || vcount1 - startCount !== 2) begin
      failures++;
      $display("[TB] FAIL overrun_flag: overrun=%b pulses=%0d expected 1 2", o1, vcount1 - startCount);
    end
    checks++;
    if (getOut(0, 0) !== eC[0] || getOut(0, 1) !== eC[1]) begin
      failures++;
      $display("[TB] FAIL overrun_out: out=%0d,%0d expected=%0d,%0d", getOut(0, 0), getOut(0, 1), eC[0], eC[1]);
    end
    expOut[0][0] = eC[0]; expOut[0][1] = eC[1];
  endtask

  task automatic test_reset_mid();
    int startCount;
    applyReset();
    doSample(0, 15000, -15000, "pre_abort");
    setIn(0, -20000, 20000);
    stb1 = 1'b1;
    tick();
    stb1 = 1'b0;
    tick();
    stb1 = 1'b1;
    rstN = 1'b0;
    #1;
    checks++;
    if (out1 !== 32'd0 || v1 !== 1'b0 || b1 !== 1'b0 || o1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_state: out=%h valid=%b busy=%b overrun=%b expected all 0", out1, v1, b1, o1);
    end
    startCount = vcount1;
    stb1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (vcount1 - startCount !== 0 || out1 !== 32'd0) begin
      failures++;
      $display("[TB] FAIL abort_no_valid: pulses=%0d out=%h expected 0 0", vcount1 - startCount, out1);
    end
    rstN = 1'b1;
    tick();
    modelReset();
    doSample(0, 10000, -10000, "after_abort");
    checks++;
    if (getOut(0, 0) !== 9907 || getOut(0, 1) !== -9906) begin
      failures++;
      $display("[TB] FAIL after_abort_literal: got=%0d,%0d expected=9907,-9906", getOut(0, 0), getOut(0, 1));
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    checks = 0;
    failures = 0;
    vcount1 = 0;
    mCoef[0] = $rtoi(65536.0 / (1.0 + 47000.0 * 47e-9 * 48000.0));
    mCoef[1] = $rtoi(65536.0 / (1.0 + 10000.0 * 1e-8 * 48000.0));
    modelReset();
    test_reset();
    test_basic();
    test_zero();
    test_random();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/resistor_capacitor_high_pass_filter.md
Name: resistor_capacitor_high_pass_filter

Overview:
Multi-channel first-order RC high-pass filter (DC blocker / coupling capacitor) for the discrete audio chain. It is the complement of the RC low-pass stage: each channel runs an internal low-pass state and outputs out = in - lp. One signed multiplier is time-shared across channels by a sequencer. Processing is triggered by audio_clk_en, with a one-deep pending request and an overrun flag.

Parameters:
NUM_CHANNELS, 2, number of independent channels (1..8)
SAMPLE_RATE, 48000, rate of audio_clk_en strobes (Hz)
R, 47000 (real), series resistor (Ohm)
C, 47e-9 (real), coupling capacitor (F)

Ports:
clk  in  1  system clock
I_RSTn  in  1  asynchronous active-low reset
audio_clk_en  in  1  one-cycle sample strobe
in  in  16*NUM_CHANNELS  signed samples; channel k at [16k+15:16k]
out  out  16*NUM_CHANNELS  signed filtered samples, same packing
out_valid  out  1  one-cycle pulse: all channels updated
busy  out  1  sequencer in RUN
overrun  out  1  sticky: a strobe was dropped

Behaviour:
- Constants: RCN = R*C*SAMPLE_RATE; M = 32-bit int(65536/(1+RCN)). Defaults give M = 612.
- Reset (I_RSTn low, async): out, lp[k], in_reg, pending, overrun, out_valid, channel index all 0; state IDLE; busy 0.
- FSM states: IDLE, RUN.
- IDLE: if audio_clk_en or pending at an edge:
  - capture all of in into in_reg
  - clear pending, set ch = 0, go to RUN.
- RUN: at each edge process channel ch:
  - diff = in_reg[ch] - lp[ch] (17-bit signed)
  - delta = (M * diff) >>> 16 (arithmetic shift; floor toward -inf)
  - lp[ch] <= lp[ch] + delta (stays within 16 bits)
  - out[ch] <= sat16(diff - delta)
  - ch increments by 1.
  - After channel NUM_CHANNELS-1: go to IDLE; out_valid = 1 for exactly that following cycle.
- Latency: strobe sampled at edge E0. Channel k's out changes at edge E0+1+k. out_valid is high during the cycle after edge E0+NUM_CHANNELS. Minimum strobe spacing without pending is NUM_CHANNELS+1 clocks.
- out holds its value between updates. Other channels' out do not change while one channel is being processed.
- busy = (state == RUN).
- audio_clk_en during RUN: set pending. That sample is captured on the first IDLE edge after RUN, i.e. from the in value present then.
- audio_clk_en during RUN with pending already set: set overrun; pending stays 1.
- audio_clk_en in IDLE while pending is set: one capture only; set overrun.
- overrun clears only on reset.
- Reset asserted mid-RUN: aborts immediately; all state returns to reset values; no out_valid.

Optional Feature:
HPF_SATURATE_EN
- Defined: sat16 clamps diff - delta to [-32768, 32767].
- Undefined: sat16 truncates to the low 16 bits (two's-complement wrap), saving comparator logic.
- lp arithmetic is identical in both builds.

Test Plan:
1. Default params, reset, ch0 in = 10000, ch1 in = -10000, single strobe -> ch0 out = 9907 after edge E0+1, ch1 out = -9906 after E0+2, out_valid at E0+2 for 1 cycle, lp0 = 93, lp1 = -94.
2. Default params, constant in = 0 for 10 strobes -> out stays 0, 10 out_valid pulses, overrun 0.
3. R=10000, C=1e-8 (M = 11299): ch0 = -32768 for 64 spaced strobes (lp converges exactly to -32768), then +32767 -> with macro out = 32767; without macro out = -11299.
4. Strobes 2 clocks apart (NUM_CHANNELS=2) -> second strobe becomes pending, processed right after the first, 2 out_valid pulses, overrun 0. Three strobes inside one RUN -> overrun = 1, only 2 out_valid pulses.
5. Assert I_RSTn low after 1 RUN cycle -> all outputs 0 immediately, no out_valid. Next strobe after release behaves as in test 1.
